seq_divmod: RTL and testbench

- Parametrised, handshaked, iterative unsigned divider producing quotient, remainder and a rounded-to-multiple value.
- Successor to the single-width repeated-subtraction modulo unit.
- Fixed latency, independent of operand values: restoring shift-subtract, one quotient bit per cycle.
- Sits between the input quantisation stage and the neuron datapath; used for rounding activations and addresses to multiples of a runtime divisor.

---
 rtl/seq_divmod.sv | 140 ++++++++++++++
 tb/tb_seq_divmod.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divmod.sv
// Iterative restoring unsigned divider: one quotient bit per clock, with
// remainder and a floor/ceiling multiple of the divisor. Valid/ready on both sides.
module seq_divmod #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DIV_W-1:0]  divisor,
    input  logic              round_up,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic [DATA_W:0]   multiple,
    output logic              div_by_zero
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] orig_q, orig_d;
    logic [DATA_W-1:0] work_q, work_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic              rup_q, rup_d;
    logic [DATA_W:0]   part_q, part_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W:0]   mul_q, mul_d;
    logic              dbz_q, dbz_d;

    logic [DATA_W:0]   shifted, part_next, floor_m, ceil_m;
    logic              take;
    logic [DATA_W-1:0] quo_final, rem_final;

    always_comb begin
        state_d = state_q;
        orig_d  = orig_q;
        work_d  = work_q;
        dvs_d   = dvs_q;
        rup_d   = rup_q;
        part_d  = part_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        mul_d   = mul_q;
        dbz_d   = dbz_q;

        // work_q shifts dividend bits out of the top while quotient bits enter at the bottom
        shifted   = {part_q[DATA_W-1:0], work_q[DATA_W-1]};
        take      = shifted >= {1'b0, dvs_q};
        part_next = take ? shifted - {1'b0, dvs_q} : shifted;
        quo_final = {work_q[DATA_W-2:0], take};
        rem_final = part_next[DATA_W-1:0];
        floor_m   = {1'b0, orig_q} - {1'b0, rem_final};
        ceil_m    = (rem_final == '0) ? {1'b0, orig_q} : floor_m + {1'b0, dvs_q};

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    orig_d = dividend;
                    work_d = dividend;
                    dvs_d  = DATA_W'(divisor);
                    rup_d  = round_up;
                    part_d = '0;
                    cnt_d  = CNT_W'(DATA_W);
                    if (divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        mul_d   = {1'b0, dividend};
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                part_d = part_next;
                work_d = quo_final;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    quo_d   = quo_final;
                    rem_d   = rem_final;
                    mul_d   = rup_q ? ceil_m : floor_m;
                    dbz_d   = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            orig_q  <= '0;
            work_q  <= '0;
            dvs_q   <= '0;
            rup_q   <= 1'b0;
            part_q  <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            mul_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            orig_q  <= orig_d;
            work_q  <= work_d;
            dvs_q   <= dvs_d;
            rup_q   <= rup_d;
            part_q  <= part_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            mul_q   <= mul_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = (state_q == StDone);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign multiple    = mul_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divmod.sv
// Bench for seq_divmod: directed cases on the default 8/5 build, then a randomized
// regression on a 12/12 build against an arithmetic reference model.
module tb_seq_divmod;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        sel;
    logic        in_valid, out_ready, round_up;
    logic [11:0] dividend, divisor;

    logic       a_in_ready, a_out_valid, a_dbz;
    logic [7:0] a_q, a_r;
    logic [8:0] a_m;

    logic        b_in_ready, b_out_valid, b_dbz;
    logic [11:0] b_q, b_r;
    logic [12:0] b_m;

    seq_divmod u_a (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid & ~sel),
        .in_ready   (a_in_ready),
        .dividend   (dividend[7:0]),
        .divisor    (divisor[4:0]),
        .round_up   (round_up),
        .out_valid  (a_out_valid),
        .out_ready  (out_ready & ~sel),
        .quotient   (a_q),
        .remainder  (a_r),
        .multiple   (a_m),
        .div_by_zero(a_dbz)
    );

    seq_divmod #(.DATA_W(12), .DIV_W(12)) u_b (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid & sel),
        .in_ready   (b_in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .round_up   (round_up),
        .out_valid  (b_out_valid),
        .out_ready  (out_ready & sel),
        .quotient   (b_q),
        .remainder  (b_r),
        .multiple   (b_m),
        .div_by_zero(b_dbz)
    );

    logic   o_ready, o_valid, o_dbz;
    longint o_q, o_r, o_m;

    always_comb begin
        if (sel) begin
            o_ready = b_in_ready;
            o_valid = b_out_valid;
            o_dbz   = b_dbz;
            o_q     = longint'(b_q);
            o_r     = longint'(b_r);
            o_m     = longint'(b_m);
        end else begin
            o_ready = a_in_ready;
            o_valid = a_out_valid;
            o_dbz   = a_dbz;
            o_q     = longint'(a_q);
            o_r     = longint'(a_r);
            o_m     = longint'(a_m);
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Latency is counted in edges from presenting the operands, accepting edge included.
    task automatic run_op(input longint a, input longint b, input bit ru, input int hold,
                          input string tag);
        int     w, lat;
        longint q, r, m;
        w = sel ? 12 : 8;
        if (b == 0) begin
            q = (longint'(1) << w) - 1;
            r = a;
            m = a;
        end else begin
            q = a / b;
            r = a % b;
            m = ru ? ((r == 0) ? a : a - r + b) : a - r;
        end
        check_eq($sformatf("%s ready", tag), longint'(o_ready), 1);
        dividend = 12'(a);
        divisor  = 12'(b);
        round_up = ru;
        in_valid = 1'b1;
        @(posedge clock); #1;
        lat      = 1;
        in_valid = 1'b0;
        dividend = 12'($urandom);
        divisor  = 12'($urandom);
        round_up = 1'($urandom);
        while (!o_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        check_eq($sformatf("%s latency", tag), lat, (b == 0) ? 1 : w + 1);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clock); #1;
            check_eq($sformatf("%s hold vld/rdy", tag), {o_valid, o_ready}, 2'b10);
        end
        in_valid = 1'b0;
        check_eq($sformatf("%s quotient", tag), o_q, q);
        check_eq($sformatf("%s remainder", tag), o_r, r);
        check_eq($sformatf("%s multiple", tag), o_m, m);
        check_eq($sformatf("%s div_by_zero", tag), longint'(o_dbz), (b == 0) ? 1 : 0);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check_eq($sformatf("%s release vld/rdy", tag), {o_valid, o_ready}, 2'b01);
    endtask

    initial begin
        sel       = 1'b0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        round_up  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clock);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            check_eq($sformatf("reset%0d vld/rdy", s), {o_valid, o_ready}, 2'b01);
            check_eq($sformatf("reset%0d outputs", s), o_q | o_r | o_m | longint'(o_dbz), 0);
        end
        sel   = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;

        run_op(200, 7, 1'b0, 0, "200/7 floor");
        run_op(200, 7, 1'b1, 0, "200/7 ceil");
        run_op(250, 31, 1'b1, 0, "250/31 ceil");
        run_op(3, 20, 1'b0, 0, "3/20 floor");
        run_op(3, 20, 1'b1, 0, "3/20 ceil");
        run_op(255, 1, 1'b1, 0, "255/1");
        run_op(13, 0, 1'b1, 0, "13/0");
        run_op(13, 5, 1'b0, 0, "13/5");
        run_op(77, 6, 1'b1, 5, "77/6 backpressure");

        // Reset in the middle of a calculation must discard it entirely.
        dividend = 12'd200;
        divisor  = 12'd7;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_eq("midreset vld/rdy", {o_valid, o_ready}, 2'b01);
        check_eq("midreset outputs", o_q | o_r | o_m | longint'(o_dbz), 0);
        run_op(100, 9, 1'b0, 0, "100/9 after reset");

        sel = 1'b1;
        #1;
        for (int n = 0; n < 1000; n++) begin
            longint a, b;
            int     gap;
            gap = $urandom_range(0, 3);
            repeat (gap) @(posedge clock);
            #1;
            a = longint'($urandom_range(0, 4095));
            case ($urandom_range(0, 7))
                0:       b = 0;
                1:       b = longint'($urandom_range(1, 15));
                default: b = longint'($urandom_range(1, 4095));
            endcase
            run_op(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   $sformatf("rnd%0d %0d/%0d", n, a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
